gray_sync_decoder: RTL and testbench

GRAY_SYNC_DECODER -- requirements
Module: gray_sync_decoder

---
 rtl/gray_sync_decoder.sv | 104 ++++++++++
 tb/tb_gray_sync_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gray_sync_decoder.sv
// -----------------------------------------------------------------------------
// gray_sync_decoder
//   Brings a Gray-coded up-counter from a foreign clock domain into clk,
//   decodes it to binary and reports how far it moved since the last sample.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   gry_in     in   [W_CTR] Gray count, asynchronous to clk
//   clr        in   synchronous clear, active high, wins over normal updates
//   count_gry  out  [W_CTR] last synchroniser stage
//   count_bin  out  [W_CTR] registered binary decode of count_gry
//   delta      out  [W_CTR] step size (mod 2^W_CTR) while advanced, else 0
//   advanced   out  one-cycle pulse when count_bin changes
//   wrapped    out  one-cycle pulse when an advance passes max -> 0
// -----------------------------------------------------------------------------
module gray_sync_decoder #(
  parameter int unsigned W_CTR  = 4,
  parameter int unsigned N_SYNC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W_CTR-1:0] gry_in,
  input  logic             clr,
  output logic [W_CTR-1:0] count_gry,
  output logic [W_CTR-1:0] count_bin,
  output logic [W_CTR-1:0] delta,
  output logic             advanced,
  output logic             wrapped
);

  // Gray to binary: MSB passes through, each lower bit folds in the one above.
  function automatic logic [W_CTR-1:0] gray2bin(input logic [W_CTR-1:0] g);
    logic [W_CTR-1:0] b;
    b[W_CTR-1] = g[W_CTR-1];
    for (int i = int'(W_CTR) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Synchroniser chain: kept as distinct flops with nothing between stages.
  (* async_reg = "true", dont_touch = "true" *)
  logic [W_CTR-1:0] sync_q [N_SYNC];
  logic [W_CTR-1:0] sync_d [N_SYNC];

  logic [W_CTR-1:0] count_bin_q, count_bin_d;
  logic [W_CTR-1:0] delta_q,     delta_d;
  logic             advanced_q,  advanced_d;
  logic             wrapped_q,   wrapped_d;

  logic [W_CTR-1:0] bin_new_c;

  // Next-state: shift the chain, decode the last stage, compare with old value.
  always_comb begin
    bin_new_c   = gray2bin(sync_q[N_SYNC-1]);
    sync_d[0]   = gry_in;
    for (int i = 1; i < int'(N_SYNC); i++) begin
      sync_d[i] = sync_q[i-1];
    end
    count_bin_d = bin_new_c;
    advanced_d  = (bin_new_c != count_bin_q);
    delta_d     = advanced_d ? W_CTR'(bin_new_c - count_bin_q) : '0;
    wrapped_d   = advanced_d && (bin_new_c < count_bin_q);

    if (clr) begin
      for (int i = 0; i < int'(N_SYNC); i++) begin
        sync_d[i] = '0;
      end
      count_bin_d = '0;
      advanced_d  = 1'b0;
      delta_d     = '0;
      wrapped_d   = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_SYNC); i++) begin
        sync_q[i] <= '0;
      end
      count_bin_q <= '0;
      delta_q     <= '0;
      advanced_q  <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(N_SYNC); i++) begin
        sync_q[i] <= sync_d[i];
      end
      count_bin_q <= count_bin_d;
      delta_q     <= delta_d;
      advanced_q  <= advanced_d;
      wrapped_q   <= wrapped_d;
    end
  end

  assign count_gry = sync_q[N_SYNC-1];
  assign count_bin = count_bin_q;
  assign delta     = delta_q;
  assign advanced  = advanced_q;
  assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
module tb_gray_sync_decoder;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gry_in;
  logic         clr;
  logic [W-1:0] count_gry, count_bin, delta;
  logic         advanced, wrapped;

  typedef struct {
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    logic         wrp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  gray_sync_decoder #(.W_CTR(W), .N_SYNC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .gry_in    (gry_in),
    .clr       (clr),
    .count_gry (count_gry),
    .count_bin (count_bin),
    .delta     (delta),
    .advanced  (advanced),
    .wrapped   (wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".count_gry"}, 32'(count_gry), 32'd0);
    chk({name, ".count_bin"}, 32'(count_bin), 32'd0);
    chk({name, ".delta"},     32'(delta),     32'd0);
    chk({name, ".advanced"},  32'(advanced),  32'd0);
    chk({name, ".wrapped"},   32'(wrapped),   32'd0);
  endtask

  // Issue one Gray value expected to produce one advance, then let it settle.
  task automatic step(input logic [W-1:0] g, input logic [W-1:0] b,
                      input logic [W-1:0] d, input logic w);
    exp_t e;
    e.bin = b; e.dlt = d; e.wrp = w;
    exp_q.push_back(e);
    gry_in = g;
    repeat (4) tick();
  endtask

  // Monitor: every advanced pulse must match the oldest expected advance.
  always @(negedge clk) begin
    if (!rst) begin
      if (advanced) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_advance: bin=%0d delta=%0d at %0t", count_bin, delta, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon.count_bin", 32'(count_bin), 32'(e.bin));
          chk("mon.delta",     32'(delta),     32'(e.dlt));
          chk("mon.wrapped",   32'(wrapped),   32'(e.wrp));
        end
      end else begin
        chk("mon.idle_delta",   32'(delta),   32'd0);
        chk("mon.idle_wrapped", 32'(wrapped), 32'd0);
      end
    end
  end

  initial begin
    rst    = 1'b1;
    clr    = 1'b0;
    gry_in = '0;
    repeat (2) tick();
    chk_zero("in_reset");
    rst = 1'b0;

    // Idle at zero for five cycles.
    repeat (5) tick();
    chk_zero("idle");

    // 0000 -> 0001: latency check (edge k is the next edge).
    begin
      exp_t e;
      e.bin = 4'd1; e.dlt = 4'd1; e.wrp = 1'b0;
      exp_q.push_back(e);
    end
    gry_in = 4'b0001;
    tick();                                   // edge k
    chk("lat.count_gry_k", 32'(count_gry), 32'd0);
    tick();                                   // edge k+1
    chk("lat.count_gry_k1", 32'(count_gry), 32'b0001);
    chk("lat.count_bin_k1", 32'(count_bin), 32'd0);
    tick();                                   // edge k+2
    chk("lat.count_bin_k2", 32'(count_bin), 32'd1);
    chk("lat.advanced_k2",  32'(advanced),  32'd1);
    tick();                                   // edge k+3
    chk("lat.advanced_k3",  32'(advanced),  32'd0);

    step(4'b0010, 4'd3,  4'd2,  1'b0);        // 1 -> 3
    step(4'b0101, 4'd6,  4'd3,  1'b0);        // 3 -> 6
    step(4'b1001, 4'd14, 4'd8,  1'b0);        // 6 -> 14
    step(4'b0001, 4'd1,  4'd3,  1'b1);        // 14 -> 1 wraps
    step(4'b1000, 4'd15, 4'd14, 1'b0);        // 1 -> 15
    step(4'b0000, 4'd0,  4'd1,  1'b1);        // 15 -> 0 wraps
    step(4'b0111, 4'd5,  4'd5,  1'b0);        // 0 -> 5
    chk("settle5.count_bin", 32'(count_bin), 32'd5);

    // Clear for one cycle, then the held value re-propagates from zero.
    begin
      exp_t e;
      e.bin = 4'd5; e.dlt = 4'd5; e.wrp = 1'b0;
      exp_q.push_back(e);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_zero("after_clr");
    tick();
    tick();
    chk("clr.count_gry_c2", 32'(count_gry), 32'b0111);
    chk("clr.count_bin_c2", 32'(count_bin), 32'd0);
    tick();
    chk("clr.count_bin_c3", 32'(count_bin), 32'd5);
    chk("clr.advanced_c3",  32'(advanced),  32'd1);
    tick();

    // Asynchronous reset while an advance pulse is on the outputs.
    gry_in = 4'b1100;                          // bin 8
    repeat (3) tick();
    chk("rstmid.advanced_before", 32'(advanced), 32'd1);
    chk("rstmid.delta_before",    32'(delta),    32'd3);
    #1 rst = 1'b1;
    #1;
    chk_zero("rst_async");
    tick();
    chk_zero("rst_held");
    begin
      exp_t e;
      e.bin = 4'd8; e.dlt = 4'd8; e.wrp = 1'b0;
      exp_q.push_back(e);
    end
    rst = 1'b0;
    repeat (4) tick();
    chk("post_rst.count_bin", 32'(count_bin), 32'd8);

    repeat (3) tick();
    chk("pending_expected", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
